// File: rtl/multi_channel_gain_pkg.sv
// multi_channel_gain_pkg
//   Shared types and helpers for the multi-channel gain stage:
//   - state_t  : sequencing FSM states
//   - deq()    : dequantize by a fraction-bit count, rounding toward zero
//   - sat_max(), sat_min() : signed full-scale limits for a given width
package multi_channel_gain_pkg;

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_MULT  = 2'd1,
      S_SCALE = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   // Callers sign-extend into 64 bits first. This keeps -x safe even
   // when x is the most negative value of the narrower sample width.
   function automatic logic signed [63:0] deq(input logic signed [63:0] x,
                                              input int                 bits);
      if (x < 0)
         return -((-x) >>> bits);
      else
         return x >>> bits;
   endfunction

   function automatic logic signed [63:0] sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/multi_channel_gain_if.sv
// multi_channel_gain_if
//   Bundles the FIFO-facing and control signals of the gain stage.
//   master : environment side (drives samples, volume, mute, FIFO flags)
//   slave  : gain stage side (drives read/write strobes and results)
//   Ports  : volume, mute, in, in_empty, in_rd_en, gain_out, out_full, out_wr_en
interface multi_channel_gain_if #(
   parameter int DATA_SIZE = 32,
   parameter int CHANNELS  = 2
);
   logic signed [DATA_SIZE-1:0]          volume;
   logic                                 mute;
   logic        [CHANNELS*DATA_SIZE-1:0] in;
   logic        [CHANNELS-1:0]           in_empty;
   logic                                 in_rd_en;
   logic        [CHANNELS*DATA_SIZE-1:0] gain_out;
   logic        [CHANNELS-1:0]           out_full;
   logic                                 out_wr_en;

   modport master (
      output volume, mute, in, in_empty, out_full,
      input  in_rd_en, gain_out, out_wr_en
   );

   modport slave (
      input  volume, mute, in, in_empty, out_full,
      output in_rd_en, gain_out, out_wr_en
   );
endinterface

// File: rtl/multi_channel_gain_lane.sv
// gain_lane
//   Combinational datapath for one audio channel. The top level owns all
//   registers; this lane only computes the next value for each stage.
//   Inputs : sample, volume (latched), d_in (registered d), s_in (registered s)
//   Outputs: d_out = DEQ(sample*volume truncated to DATA_SIZE)
//            s_out = d_in <<< GAIN_SHIFT (wrapped, or clamped when
//                    MULTI_CHANNEL_GAIN_SATURATE_EN is defined)
//            y_out = DEQ(s_in)
module gain_lane
   import multi_channel_gain_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int BITS       = 10,
   parameter int GAIN_SHIFT = 14
) (
   input  logic signed [DATA_SIZE-1:0] sample,
   input  logic signed [DATA_SIZE-1:0] volume,
   input  logic signed [DATA_SIZE-1:0] d_in,
   input  logic signed [DATA_SIZE-1:0] s_in,
   output logic signed [DATA_SIZE-1:0] d_out,
   output logic signed [DATA_SIZE-1:0] s_out,
   output logic signed [DATA_SIZE-1:0] y_out
);

   logic signed [DATA_SIZE-1:0] p;
   logic signed [DATA_SIZE-1:0] s_wrap;

   // Product kept at DATA_SIZE bits on purpose: the software reference
   // model truncates here too, and bit-exactness matters more than range.
   assign p      = sample * volume;
   assign d_out  = DATA_SIZE'(deq(64'(p), BITS));
   assign s_wrap = d_in <<< GAIN_SHIFT;
   assign y_out  = DATA_SIZE'(deq(64'(s_in), BITS));

`ifdef MULTI_CHANNEL_GAIN_SATURATE_EN
   localparam logic signed [DATA_SIZE-1:0] S_MAX = DATA_SIZE'(sat_max(DATA_SIZE));
   localparam logic signed [DATA_SIZE-1:0] S_MIN = DATA_SIZE'(sat_min(DATA_SIZE));

   // Clamp on the pre-shift value so the overflow test never needs
   // bits that the shift would throw away.
   always_comb begin
      s_out = s_wrap;
      if (d_in > (S_MAX >>> GAIN_SHIFT))
         s_out = S_MAX;
      else if (d_in < (S_MIN >>> GAIN_SHIFT))
         s_out = S_MIN;
   end
`else
   assign s_out = s_wrap;
`endif

endmodule

// File: rtl/multi_channel_gain.sv
// multi_channel_gain
//   N-channel lockstep fixed-point gain stage between the de-emphasis
//   FIFOs and the audio output FIFOs. One sample set per 4 cycles.
//   Ports : clock, reset (async, active-high), bus (multi_channel_gain_if.slave)
//   Option: MULTI_CHANNEL_GAIN_SATURATE_EN selects clamping in S_SCALE
//           (inside gain_lane); undefined gives wrap-around truncation.
//
//   state   | meaning
//   S_READ  | wait until every input FIFO has data, then latch all samples,
//           | volume and mute together
//   S_MULT  | register d = DEQ(sample * volume)
//   S_SCALE | register s = d <<< GAIN_SHIFT (wrapped or clamped)
//   S_WRITE | wait until no output FIFO is full, then present DEQ(s)
//           | (or zero when muted) with out_wr_en
module multi_channel_gain
   import multi_channel_gain_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int CHANNELS   = 2,
   parameter int BITS       = 10,
   parameter int GAIN_SHIFT = 14
) (
   input logic                  clock,
   input logic                  reset,
   multi_channel_gain_if.slave  bus
);

   state_t                              state_q, state_d;
   logic signed [DATA_SIZE-1:0]         sample_q [CHANNELS];
   logic signed [DATA_SIZE-1:0]         sample_d [CHANNELS];
   logic signed [DATA_SIZE-1:0]         d_q      [CHANNELS];
   logic signed [DATA_SIZE-1:0]         d_d      [CHANNELS];
   logic signed [DATA_SIZE-1:0]         s_q      [CHANNELS];
   logic signed [DATA_SIZE-1:0]         s_d      [CHANNELS];
   logic signed [DATA_SIZE-1:0]         volume_q, volume_d;
   logic                                mute_q, mute_d;
   logic                                in_rd_en_q, in_rd_en_d;
   logic                                out_wr_en_q, out_wr_en_d;
   logic        [CHANNELS*DATA_SIZE-1:0] gain_out_q, gain_out_d;

   logic signed [DATA_SIZE-1:0]         d_lane [CHANNELS];
   logic signed [DATA_SIZE-1:0]         s_lane [CHANNELS];
   logic signed [DATA_SIZE-1:0]         y_lane [CHANNELS];

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      gain_lane #(
         .DATA_SIZE  (DATA_SIZE),
         .BITS       (BITS),
         .GAIN_SHIFT (GAIN_SHIFT)
      ) u_lane (
         .sample (sample_q[k]),
         .volume (volume_q),
         .d_in   (d_q[k]),
         .s_in   (s_q[k]),
         .d_out  (d_lane[k]),
         .s_out  (s_lane[k]),
         .y_out  (y_lane[k])
      );
   end

   always_comb begin
      state_d     = state_q;
      sample_d    = sample_q;
      d_d         = d_q;
      s_d         = s_q;
      volume_d    = volume_q;
      mute_d      = mute_q;
      in_rd_en_d  = 1'b0;
      out_wr_en_d = 1'b0;
      // Output bus reads zero in every cycle without a write strobe.
      gain_out_d  = '0;

      case (state_q)
         S_READ: begin
            // All-or-nothing read keeps the channels in lockstep.
            if (bus.in_empty == '0) begin
               in_rd_en_d = 1'b1;
               for (int k = 0; k < CHANNELS; k++)
                  sample_d[k] = bus.in[k*DATA_SIZE +: DATA_SIZE];
               volume_d = bus.volume;
               mute_d   = bus.mute;
               state_d  = S_MULT;
            end
         end
         S_MULT: begin
            d_d     = d_lane;
            state_d = S_SCALE;
         end
         S_SCALE: begin
            s_d     = s_lane;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (bus.out_full == '0) begin
               out_wr_en_d = 1'b1;
               for (int k = 0; k < CHANNELS; k++)
                  gain_out_d[k*DATA_SIZE +: DATA_SIZE] = mute_q ? '0 : y_lane[k];
               state_d = S_READ;
            end
         end
         default: state_d = S_READ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_READ;
         volume_q    <= '0;
         mute_q      <= 1'b0;
         in_rd_en_q  <= 1'b0;
         out_wr_en_q <= 1'b0;
         gain_out_q  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            sample_q[k] <= '0;
            d_q[k]      <= '0;
            s_q[k]      <= '0;
         end
      end else begin
         state_q     <= state_d;
         volume_q    <= volume_d;
         mute_q      <= mute_d;
         in_rd_en_q  <= in_rd_en_d;
         out_wr_en_q <= out_wr_en_d;
         gain_out_q  <= gain_out_d;
         sample_q    <= sample_d;
         d_q         <= d_d;
         s_q         <= s_d;
      end
   end

   assign bus.in_rd_en  = in_rd_en_q;
   assign bus.out_wr_en = out_wr_en_q;
   assign bus.gain_out  = gain_out_q;

endmodule

// File: tb/tb_multi_channel_gain.sv
module tb_multi_channel_gain;

   localparam int DS = 32;
   localparam int CH = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   multi_channel_gain_if #(.DATA_SIZE(DS), .CHANNELS(CH)) bus ();

   multi_channel_gain #(
      .DATA_SIZE  (DS),
      .CHANNELS   (CH),
      .BITS       (10),
      .GAIN_SHIFT (14)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic signed [31:0] in0;
      logic signed [31:0] in1;
      logic signed [31:0] vol;
      logic               mute;
      logic signed [31:0] e0;
      logic signed [31:0] e1;
   } vec_t;

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic signed [31:0] a, input logic signed [31:0] b);
      bus.in = {b, a};
   endtask

   task automatic wait_rd(input string nm);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.in_rd_en && n < 20);
      check({nm, " rd_en"}, longint'(bus.in_rd_en), 1);
      check({nm, " no wr with rd"}, longint'(bus.out_wr_en), 0);
   endtask

   task automatic wait_wr(input string nm, input int exp_lat,
                          input longint e0, input longint e1);
      int n = 0;
      logic signed [31:0] g0, g1;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.out_wr_en && n < 40);
      check({nm, " wr_en"}, longint'(bus.out_wr_en), 1);
      if (exp_lat >= 0)
         check({nm, " latency"}, longint'(n), longint'(exp_lat));
      g0 = bus.gain_out[31:0];
      g1 = bus.gain_out[63:32];
      check({nm, " ch0"}, g0, e0);
      check({nm, " ch1"}, g1, e1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [7];
      int   cnt;
      logic signed [31:0] g0, g1;

      vecs[0] = '{1000,     -1000,    1024,  1'b0, 16000,  -16000};
      vecs[1] = '{3,        -1500,    1,     1'b0, 0,      -16};
      vecs[2] = '{500,      500,      1024,  1'b1, 0,      0};
`ifdef MULTI_CHANNEL_GAIN_SATURATE_EN
      vecs[3] = '{1048576,  -1048576, 1024,  1'b0, 2097151, -2097152};
`else
      vecs[3] = '{1048576,  -1048576, 1024,  1'b0, 0,      0};
`endif
      vecs[4] = '{-7,       2048,     512,   1'b0, -48,    16384};
      vecs[5] = '{0,        123,      1024,  1'b0, 0,      1968};
      vecs[6] = '{100,      -100,     -2048, 1'b0, -3200,  3200};

      bus.volume   = 1024;
      bus.mute     = 1'b0;
      bus.in       = '0;
      bus.in_empty = 2'b11;
      bus.out_full = 2'b00;

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset rd_en", longint'(bus.in_rd_en), 0);
      check("reset wr_en", longint'(bus.out_wr_en), 0);
      check("reset gain_out", longint'(bus.gain_out), 0);
      reset = 1'b0;
      @(negedge clock);

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         set_in(vecs[i].in0, vecs[i].in1);
         bus.volume   = vecs[i].vol;
         bus.mute     = vecs[i].mute;
         bus.in_empty = 2'b00;
         wait_rd($sformatf("vec%0d", i));
         bus.in_empty = 2'b11;
         wait_wr($sformatf("vec%0d", i), 3, vecs[i].e0, vecs[i].e1);
      end
      bus.volume = 1024;
      bus.mute   = 1'b0;

      @(negedge clock);
      check("idle gain_out zero", longint'(bus.gain_out), 0);

      // One empty channel stalls both
      set_in(11, 22);
      bus.in_empty = 2'b10;
      cnt = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.in_rd_en) cnt++;
      end
      check("stall no read", longint'(cnt), 0);
      bus.in_empty = 2'b00;
      wait_rd("stall release");
      bus.in_empty = 2'b11;
      wait_wr("stall", 3, 176, 352);
      cnt = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus.in_rd_en) cnt++;
      end
      check("stall single read", longint'(cnt), 0);

      // Output backpressure held in S_WRITE
      set_in(5, 6);
      bus.out_full = 2'b01;
      bus.in_empty = 2'b00;
      wait_rd("full");
      bus.in_empty = 2'b11;
      cnt = 0;
      repeat (10) begin
         @(negedge clock);
         if (bus.out_wr_en || bus.gain_out != '0) cnt++;
      end
      check("full holds", longint'(cnt), 0);
      bus.out_full = 2'b00;
      @(negedge clock);
      check("full release wr_en", longint'(bus.out_wr_en), 1);
      g0 = bus.gain_out[31:0];
      g1 = bus.gain_out[63:32];
      check("full release ch0", g0, 80);
      check("full release ch1", g1, 96);

      // Mute latched at read only; volume change mid-sample ignored
      set_in(500, 500);
      bus.mute     = 1'b1;
      bus.in_empty = 2'b00;
      wait_rd("mute");
      bus.mute     = 1'b0;
      bus.in_empty = 2'b11;
      wait_wr("mute", 3, 0, 0);
      bus.in_empty = 2'b00;
      wait_rd("unmuted");
      bus.volume   = 0;
      bus.mute     = 1'b1;
      bus.in_empty = 2'b11;
      wait_wr("unmuted", 3, 8000, 8000);
      bus.volume = 1024;
      bus.mute   = 1'b0;

      // Reset during S_SCALE discards the sample
      set_in(1000, 1000);
      bus.in_empty = 2'b00;
      wait_rd("rst");
      bus.in_empty = 2'b11;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst async wr_en", longint'(bus.out_wr_en), 0);
      check("rst async gain_out", longint'(bus.gain_out), 0);
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus.out_wr_en || bus.gain_out != '0) cnt++;
      end
      check("rst no write", longint'(cnt), 0);
      bus.in_empty = 2'b00;
      @(negedge clock);
      check("rst back in S_READ", longint'(bus.in_rd_en), 1);
      bus.in_empty = 2'b11;
      wait_wr("post rst", 3, 16000, 16000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
